// File: rtl/f1_pkg.sv
// f1_pkg: shared state encoding and lamp decode for the F1 start-light sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package f1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        HOLD,
        REACT,
        FAULT
    } f1_state_t;

    // Widest lamp bank the thermometer decode supports; callers cast the
    // result down to their own N_LIGHTS width.
    localparam int unsigned THERM_MAX = 64;

    // Thermometer decode: bit i is set for every i < lit.
    function automatic logic [THERM_MAX-1:0] therm(input int unsigned lit);
        logic [THERM_MAX-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < THERM_MAX; i++) begin
            t[i] = (i < lit);
        end
        return t;
    endfunction

endpackage

// File: rtl/f1_sat_counter.sv
// f1_sat_counter: up-counter with synchronous clear that sticks at all-ones.
// Latency: count visible 1 cycle after an enabled cycle; clear wins over enable.
// Backpressure: none; en is a plain strobe and is simply ignored once saturated.
module f1_sat_counter
    import f1_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         sysclk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Count enabled cycles, holding at the maximum instead of wrapping.
    always_ff @(posedge sysclk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/f1_start_sequencer.sv
// f1_start_sequencer: lights lamps one per TICKS_PER_LIGHT ticks, holds for a random delay, pulses go, times the response.
// Latency: trigger to COUNT 1 cycle; go and result_valid are registered; ledr/busy/en_lfsr decode registered state.
// Backpressure: none; tick, trigger and response are sampled every cycle and never stalled.
module f1_start_sequencer
    import f1_pkg::*;
#(
    parameter int N_LIGHTS        = 10,
    parameter int TICKS_PER_LIGHT = 1,
    parameter int DELAY_W         = 14,
    parameter int MIN_DELAY       = 250,
    parameter int RT_W            = 10
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                tick,
    input  logic                trigger,
    input  logic                response,
    input  logic [DELAY_W-1:0]  rand_val,
    output logic                en_lfsr,
    output logic [N_LIGHTS-1:0] ledr,
    output logic                busy,
    output logic                go,
    output logic                result_valid,
    output logic [RT_W-1:0]     react_time,
    output logic                jump_start
);

    localparam int LIT_W  = $clog2(N_LIGHTS + 1);
    localparam int SUB_W  = (TICKS_PER_LIGHT > 1) ? $clog2(TICKS_PER_LIGHT) : 1;
    localparam int HOLD_W = DELAY_W + 1;

    localparam logic [LIT_W-1:0]  LIT_FULL = LIT_W'(N_LIGHTS);
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(TICKS_PER_LIGHT - 1);
    localparam logic [HOLD_W-1:0] MIN_HOLD = HOLD_W'(MIN_DELAY);

    f1_state_t         state, state_nxt;
    logic [LIT_W-1:0]  lit, lit_nxt;
    logic [SUB_W-1:0]  sub, sub_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              go_nxt;
    logic              rv_nxt;
    logic              js_nxt;
    logic [RT_W-1:0]   rt_nxt;
    logic              react_clr;
    logic              react_en;
    logic [RT_W-1:0]   react_cnt;

    // Reaction timer: cleared on the go transition, advanced by ticks in REACT.
    f1_sat_counter #(
        .W (RT_W)
    ) u_react_cnt (
        .sysclk (sysclk),
        .reset  (reset),
        .clr    (react_clr),
        .en     (react_en),
        .cnt    (react_cnt)
    );

    // State, lamp counters, hold timer and registered outputs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state        <= IDLE;
            lit          <= '0;
            sub          <= '0;
            hold_cnt     <= '0;
            go           <= 1'b0;
            result_valid <= 1'b0;
            react_time   <= '0;
            jump_start   <= 1'b0;
        end else begin
            state        <= state_nxt;
            lit          <= lit_nxt;
            sub          <= sub_nxt;
            hold_cnt     <= hold_nxt;
            go           <= go_nxt;
            result_valid <= rv_nxt;
            react_time   <= rt_nxt;
            jump_start   <= js_nxt;
        end
    end

    // Next-state and next-value logic; response checks come first so a
    // jump start always beats lamp progress or the final hold tick.
    always_comb begin
        state_nxt = state;
        lit_nxt   = lit;
        sub_nxt   = sub;
        hold_nxt  = hold_cnt;
        go_nxt    = 1'b0;
        rv_nxt    = 1'b0;
        js_nxt    = jump_start;
        rt_nxt    = react_time;
        react_clr = 1'b0;
        react_en  = (state == REACT) && tick;

        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = COUNT;
                    lit_nxt   = '0;
                    sub_nxt   = '0;
                    js_nxt    = 1'b0;
                end
            end

            COUNT: begin
                if (response) begin
                    state_nxt = FAULT;
                    js_nxt    = 1'b1;
                    rv_nxt    = 1'b1;
                end else if (lit == LIT_FULL) begin
                    // Widened by one bit so MIN_DELAY + rand_val cannot wrap.
                    state_nxt = HOLD;
                    hold_nxt  = {1'b0, rand_val} + MIN_HOLD;
                end else if (tick) begin
                    if (sub == SUB_LAST) begin
                        sub_nxt = '0;
                        lit_nxt = lit + LIT_W'(1);
                    end else begin
                        sub_nxt = sub + SUB_W'(1);
                    end
                end
            end

            HOLD: begin
                if (response) begin
                    state_nxt = FAULT;
                    js_nxt    = 1'b1;
                    rv_nxt    = 1'b1;
                end else if (hold_cnt == '0) begin
                    // Zero-length hold: lights out straight away.
                    state_nxt = REACT;
                    go_nxt    = 1'b1;
                    react_clr = 1'b1;
                end else if (tick) begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                    if (hold_cnt == HOLD_W'(1)) begin
                        state_nxt = REACT;
                        go_nxt    = 1'b1;
                        react_clr = 1'b1;
                    end
                end
            end

            REACT: begin
                // Captured value is pre-increment, so a coincident tick is excluded.
                if (response) begin
                    state_nxt = IDLE;
                    rt_nxt    = react_cnt;
                    rv_nxt    = 1'b1;
                end
            end

            FAULT: begin
                // Restart takes priority over any coincident response.
                if (trigger) begin
                    state_nxt = COUNT;
                    lit_nxt   = '0;
                    sub_nxt   = '0;
                    js_nxt    = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Lamp, busy and LFSR-enable decode from registered state only.
    always_comb begin
        ledr    = '0;
        busy    = 1'b0;
        en_lfsr = 1'b0;
        case (state)
            IDLE: begin
                en_lfsr = 1'b1;
            end
            COUNT: begin
                en_lfsr = 1'b1;
                busy    = 1'b1;
                ledr    = N_LIGHTS'(therm(32'(lit)));
            end
            HOLD: begin
                busy = 1'b1;
                ledr = '1;
            end
            REACT: begin
                busy = 1'b1;
            end
            default: begin
                ledr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_f1_start_sequencer.sv
// tb_f1_start_sequencer: scenario bench for the start-light sequencer.
// Latency: inputs driven 1 time unit after posedge, outputs sampled there too.
// Backpressure: n/a.
module tb_f1_start_sequencer;

    localparam int N_LIGHTS  = 5;
    localparam int TPL       = 2;
    localparam int DELAY_W   = 4;
    localparam int MIN_DELAY = 3;
    localparam int RT_W      = 8;

    logic                sysclk = 1'b0;
    logic                reset;
    logic                tick;
    logic                trigger;
    logic                response;
    logic [DELAY_W-1:0]  rand_val;
    logic                en_lfsr;
    logic [N_LIGHTS-1:0] ledr;
    logic                busy;
    logic                go;
    logic                result_valid;
    logic [RT_W-1:0]     react_time;
    logic                jump_start;

    typedef struct packed {
        logic [RT_W-1:0] rt;
        logic            js;
    } res_t;

    res_t            sb_q[$];
    int              n_cmp = 0;
    int              n_fail = 0;
    int              go_cnt = 0;
    int              rv_cnt = 0;
    int              overlap_cnt = 0;
    logic [RT_W-1:0] last_rt;

    always #5 sysclk = ~sysclk;

    f1_start_sequencer #(
        .N_LIGHTS        (N_LIGHTS),
        .TICKS_PER_LIGHT (TPL),
        .DELAY_W         (DELAY_W),
        .MIN_DELAY       (MIN_DELAY),
        .RT_W            (RT_W)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .tick         (tick),
        .trigger      (trigger),
        .response     (response),
        .rand_val     (rand_val),
        .en_lfsr      (en_lfsr),
        .ledr         (ledr),
        .busy         (busy),
        .go           (go),
        .result_valid (result_valid),
        .react_time   (react_time),
        .jump_start   (jump_start)
    );

    // Pulse bookkeeping on the quiet edge.
    always @(negedge sysclk) begin
        if (reset === 1'b0) begin
            if (go === 1'b1) go_cnt++;
            if (result_valid === 1'b1) rv_cnt++;
            if (go === 1'b1 && result_valid === 1'b1) overlap_cnt++;
        end
    end

    task automatic step(input logic t, input logic r, input logic trg);
        tick     = t;
        response = r;
        trigger  = trg;
        @(posedge sysclk);
        #1;
        tick     = 1'b0;
        response = 1'b0;
        trigger  = 1'b0;
    endtask

    // One tick period: three quiet cycles then a tick cycle.
    task automatic tick_period(input logic resp, input logic trg);
        step(1'b0, 1'b0, trg);
        step(1'b0, 1'b0, trg);
        step(1'b0, 1'b0, trg);
        step(1'b1, resp, trg);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rand_val = 4'd4;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({ledr, go, result_valid, busy, jump_start, react_time, en_lfsr} !==
            {5'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got ledr=%b go=%b rv=%b busy=%b js=%b rt=%0d en=%b want 0/0/0/0/0/0/1",
                     ledr, go, result_valid, busy, jump_start, react_time, en_lfsr);
        end
        reset   = 1'b0;
        last_rt = '0;
    endtask

    task automatic test_normal_run();
        int                  g0, r0;
        logic [N_LIGHTS-1:0] exp_l;
        res_t                exp_r;
        g0 = go_cnt;
        r0 = rv_cnt;
        rand_val = 4'd4;
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (busy !== 1'b1 || ledr !== '0 || en_lfsr !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_count_entry: got busy=%b ledr=%b en=%b want 1/00000/1", busy, ledr, en_lfsr);
        end
        for (int t = 1; t <= N_LIGHTS * TPL; t++) begin
            tick_period(1'b0, 1'b0);
            exp_l = N_LIGHTS'((1 << (t / TPL)) - 1);
            n_cmp++;
            if (ledr !== exp_l) begin
                n_fail++;
                $display("FAIL normal_ledr tick %0d: got %b want %b", t, ledr, exp_l);
            end
        end
        for (int h = 1; h <= 7; h++) begin
            tick_period(1'b0, 1'b0);
            n_cmp++;
            if (h < 7) begin
                if (ledr !== 5'b11111 || go !== 1'b0 || busy !== 1'b1 || en_lfsr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL normal_hold tick %0d: got ledr=%b go=%b busy=%b en=%b want 11111/0/1/0",
                             h, ledr, go, busy, en_lfsr);
                end
            end else if (go !== 1'b1 || ledr !== '0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL normal_go: got go=%b ledr=%b busy=%b want 1/00000/1", go, ledr, busy);
            end
        end
        for (int k = 0; k < 12; k++) tick_period(1'b0, 1'b0);
        exp_r.rt = 8'd12;
        exp_r.js = 1'b0;
        sb_q.push_back(exp_r);
        step(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL normal_result: scoreboard empty");
        end else begin
            exp_r = sb_q.pop_front();
            if (result_valid !== 1'b1 || react_time !== exp_r.rt || jump_start !== exp_r.js) begin
                n_fail++;
                $display("FAIL normal_result: got rv=%b rt=%0d js=%b want rv=1 rt=%0d js=%b",
                         result_valid, react_time, jump_start, exp_r.rt, exp_r.js);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (go_cnt - g0 != 1 || rv_cnt - r0 != 1 || busy !== 1'b0 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL normal_pulses: got go=%0d rv=%0d busy=%b want go=1 rv=1 busy=0",
                     go_cnt - g0, rv_cnt - r0, busy);
        end
        last_rt = 8'd12;
    endtask

    // Leaves the DUT in FAULT.
    task automatic test_jump_start();
        int   g0;
        res_t exp_r;
        g0 = go_cnt;
        rand_val = 4'd4;
        step(1'b0, 1'b0, 1'b1);
        for (int t = 0; t < N_LIGHTS * TPL; t++) tick_period(1'b0, 1'b0);
        tick_period(1'b0, 1'b0);
        tick_period(1'b0, 1'b0);
        exp_r.rt = last_rt;
        exp_r.js = 1'b1;
        sb_q.push_back(exp_r);
        tick_period(1'b1, 1'b0);
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL jump_result: scoreboard empty");
        end else begin
            exp_r = sb_q.pop_front();
            if (result_valid !== 1'b1 || react_time !== exp_r.rt || jump_start !== exp_r.js ||
                ledr !== '0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL jump_result: got rv=%b rt=%0d js=%b ledr=%b busy=%b want rv=1 rt=%0d js=1 ledr=0 busy=0",
                         result_valid, react_time, jump_start, ledr, busy, exp_r.rt);
            end
        end
        for (int k = 0; k < 6; k++) tick_period(1'b0, 1'b0);
        n_cmp++;
        if (go_cnt != g0 || jump_start !== 1'b1 || ledr !== '0) begin
            n_fail++;
            $display("FAIL jump_hold: got go_pulses=%0d js=%b ledr=%b want 0/1/00000", go_cnt - g0, jump_start, ledr);
        end
    endtask

    // Entered from FAULT, leaves the DUT in FAULT.
    task automatic test_coincidence();
        int   g0;
        res_t exp_r;
        g0 = go_cnt;
        step(1'b0, 1'b0, 1'b1);
        for (int t = 0; t < N_LIGHTS * TPL; t++) tick_period(1'b0, 1'b0);
        for (int h = 0; h < 6; h++) tick_period(1'b0, 1'b0);
        exp_r.rt = last_rt;
        exp_r.js = 1'b1;
        sb_q.push_back(exp_r);
        tick_period(1'b1, 1'b0);
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL coinc_result: scoreboard empty");
        end else begin
            exp_r = sb_q.pop_front();
            if (result_valid !== 1'b1 || react_time !== exp_r.rt || jump_start !== exp_r.js || go !== 1'b0) begin
                n_fail++;
                $display("FAIL coinc_result: got rv=%b rt=%0d js=%b go=%b want rv=1 rt=%0d js=1 go=0",
                         result_valid, react_time, jump_start, go, exp_r.rt);
            end
        end
        for (int k = 0; k < 3; k++) tick_period(1'b0, 1'b0);
        n_cmp++;
        if (go_cnt != g0) begin
            n_fail++;
            $display("FAIL coinc_no_go: got %0d go pulses want 0", go_cnt - g0);
        end
    endtask

    // Entered from FAULT; finishes a full run with a tick-coincident response.
    task automatic test_restart_fault();
        res_t exp_r;
        step(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (jump_start !== 1'b0 || busy !== 1'b1 || result_valid !== 1'b0 || en_lfsr !== 1'b1 || ledr !== '0) begin
            n_fail++;
            $display("FAIL restart_entry: got js=%b busy=%b rv=%b en=%b ledr=%b want 0/1/0/1/00000",
                     jump_start, busy, result_valid, en_lfsr, ledr);
        end
        tick_period(1'b0, 1'b0);
        tick_period(1'b0, 1'b0);
        n_cmp++;
        if (ledr !== 5'b00001) begin
            n_fail++;
            $display("FAIL restart_lit: got %b want 00001", ledr);
        end
        for (int t = 2; t < N_LIGHTS * TPL; t++) tick_period(1'b0, 1'b0);
        for (int h = 0; h < 7; h++) tick_period(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) tick_period(1'b0, 1'b0);
        exp_r.rt = 8'd3;
        exp_r.js = 1'b0;
        sb_q.push_back(exp_r);
        tick_period(1'b1, 1'b0);
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL react_coinc: scoreboard empty");
        end else begin
            exp_r = sb_q.pop_front();
            if (result_valid !== 1'b1 || react_time !== exp_r.rt || jump_start !== exp_r.js) begin
                n_fail++;
                $display("FAIL react_coinc: got rv=%b rt=%0d js=%b want rv=1 rt=%0d js=0",
                         result_valid, react_time, jump_start, exp_r.rt);
            end
        end
        last_rt = 8'd3;
    endtask

    task automatic test_ignore_trigger();
        res_t exp_r;
        rand_val = 4'd9;
        step(1'b0, 1'b0, 1'b1);
        for (int t = 0; t < N_LIGHTS * TPL; t++) tick_period(1'b0, 1'b0);
        for (int h = 1; h <= 12; h++) begin
            tick_period(1'b0, 1'b1);
            if (h == 11) begin
                n_cmp++;
                if (busy !== 1'b1 || ledr !== 5'b11111 || go !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignore_hold: got busy=%b ledr=%b go=%b want 1/11111/0", busy, ledr, go);
                end
            end
        end
        n_cmp++;
        if (go !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_go: got go=%b want 1 after 12 hold ticks", go);
        end
        tick_period(1'b0, 1'b1);
        tick_period(1'b0, 1'b1);
        exp_r.rt = 8'd2;
        exp_r.js = 1'b0;
        sb_q.push_back(exp_r);
        step(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL ignore_result: scoreboard empty");
        end else begin
            exp_r = sb_q.pop_front();
            if (result_valid !== 1'b1 || react_time !== exp_r.rt || jump_start !== exp_r.js) begin
                n_fail++;
                $display("FAIL ignore_result: got rv=%b rt=%0d js=%b want rv=1 rt=%0d js=0",
                         result_valid, react_time, jump_start, exp_r.rt);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (busy !== 1'b0 || ledr !== '0) begin
            n_fail++;
            $display("FAIL ignore_idle: got busy=%b ledr=%b want 0/00000", busy, ledr);
        end
        last_rt = 8'd2;
    endtask

    task automatic test_saturation();
        res_t exp_r;
        rand_val = 4'd0;
        step(1'b0, 1'b0, 1'b1);
        for (int t = 0; t < N_LIGHTS * TPL; t++) tick_period(1'b0, 1'b0);
        for (int h = 0; h < MIN_DELAY; h++) tick_period(1'b0, 1'b0);
        n_cmp++;
        if (go !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_go: got go=%b want 1 after 3 hold ticks", go);
        end
        for (int k = 0; k < 300; k++) tick_period(1'b0, 1'b0);
        exp_r.rt = 8'd255;
        exp_r.js = 1'b0;
        sb_q.push_back(exp_r);
        step(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sat_result: scoreboard empty");
        end else begin
            exp_r = sb_q.pop_front();
            if (result_valid !== 1'b1 || react_time !== exp_r.rt || jump_start !== exp_r.js) begin
                n_fail++;
                $display("FAIL sat_result: got rv=%b rt=%0d js=%b want rv=1 rt=%0d js=0",
                         result_valid, react_time, jump_start, exp_r.rt);
            end
        end
        last_rt = 8'd255;
    endtask

    task automatic test_reset_mid_hold();
        rand_val = 4'd4;
        step(1'b0, 1'b0, 1'b1);
        for (int t = 0; t < N_LIGHTS * TPL; t++) tick_period(1'b0, 1'b0);
        tick_period(1'b0, 1'b0);
        tick_period(1'b0, 1'b0);
        n_cmp++;
        if (ledr !== 5'b11111 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midhold_pre: got ledr=%b busy=%b want 11111/1", ledr, busy);
        end
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        n_cmp++;
        if ({ledr, busy, en_lfsr, go, result_valid, jump_start, react_time} !==
            {5'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL midhold_reset: got ledr=%b busy=%b en=%b go=%b rv=%b js=%b rt=%0d want 0/0/1/0/0/0/0",
                     ledr, busy, en_lfsr, go, result_valid, jump_start, react_time);
        end
        last_rt = '0;
        step(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || jump_start !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_response: got rv=%b busy=%b js=%b want 0/0/0", result_valid, busy, jump_start);
        end
    endtask

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        trigger  = 1'b0;
        response = 1'b0;
        rand_val = '0;
        test_reset();
        test_normal_run();
        test_jump_start();
        test_coincidence();
        test_restart_fault();
        test_ignore_trigger();
        test_saturation();
        test_reset_mid_hold();
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (overlap_cnt != 0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL final: got go/rv overlaps=%0d pending=%0d want 0/0", overlap_cnt, sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
